if_fetch: RTL

Instruction-fetch stage that directly feeds the IF/ID pipeline register.
- Owns the PC and issues one-outstanding-request reads to instruction memory.
- Buffers the returned word until the downstream stall (stop) releases it.
- Handles branch/jump redirects from later stages, discarding stale in-flight responses.
- Drives if_inst/if_pc/if_npc; presents a NOP bubble whenever no valid instruction is ready.

---
 rtl/if_fetch_pkg.sv | 18 +
 rtl/if_fetch.sv | 115 +++++++++++
 2 files changed

// File: rtl/if_fetch_pkg.sv
// Shared fetch-stage definitions: state encodings, reset PC and the NOP bubble word.
package if_fetch_pkg;

    localparam logic [31:0] PC_INITIAL = 32'h0000_0000;
    localparam logic [31:0] NOP_WORD   = 32'h0000_0013;

    typedef enum logic [1:0] {
        FS_REQ  = 2'd0,
        FS_WAIT = 2'd1,
        FS_HOLD = 2'd2
    } fetch_state_e;

    // Redirect targets may carry stray low bits; fetch addresses are always word aligned.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, keeps one imem read in flight, buffers the
// returned word until the IF/ID stall releases it, and squashes stale responses on redirect.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_INITIAL,
    parameter logic [31:0] NOP_INST = NOP_WORD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stop,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic [31:0] if_npc
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         kill_q, kill_d;
    logic [31:0]  inst_buf_q, inst_buf_d;

    logic         req;
    logic [31:0]  addr;
    logic         valid;
    logic [31:0]  pc_out;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        kill_d     = kill_q;
        inst_buf_d = inst_buf_q;
        req        = 1'b0;
        addr       = pc_q;
        valid      = 1'b0;

        case (state_q)
            FS_REQ: begin
                if (redirect) begin
                    pc_d = word_align(redirect_pc);
                end else begin
                    req     = 1'b1;
                    state_d = FS_WAIT;
                end
            end
            FS_WAIT: begin
                if (redirect) begin
                    pc_d = word_align(redirect_pc);
                    // A response landing with the redirect settles the outstanding request.
                    if (imem_rvalid) begin
                        kill_d  = 1'b0;
                        state_d = FS_REQ;
                    end else begin
                        kill_d = 1'b1;
                    end
                end else if (imem_rvalid) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = FS_REQ;
                    end else begin
                        inst_buf_d = imem_rdata;
                        state_d    = FS_HOLD;
                    end
                end
            end
            FS_HOLD: begin
                if (redirect) begin
                    pc_d    = word_align(redirect_pc);
                    state_d = FS_REQ;
                end else begin
                    valid = 1'b1;
                    if (!stop) begin
                        req     = 1'b1;
                        addr    = pc_q + 32'd4;
                        pc_d    = pc_q + 32'd4;
                        state_d = FS_WAIT;
                    end
                end
            end
            default: state_d = FS_REQ;
        endcase

        // Reset also silences the outputs in the very cycle it is asserted.
        if (rst) begin
            state_d    = FS_REQ;
            pc_d       = PC_RESET;
            kill_d     = 1'b0;
            inst_buf_d = NOP_INST;
            req        = 1'b0;
            valid      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        state_q    <= state_d;
        pc_q       <= pc_d;
        kill_q     <= kill_d;
        inst_buf_q <= inst_buf_d;
    end

    assign pc_out    = rst ? PC_RESET : pc_q;
    assign imem_req  = req;
    assign imem_addr = addr;
    assign if_valid  = valid;
    assign if_inst   = valid ? inst_buf_q : NOP_INST;
    assign if_pc     = pc_out;
    assign if_npc    = pc_out + 32'd4;

endmodule
